// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with req/ready handshake, programmable wait states and
// LB/LBU/LH/LHU/LW/SB/SH/SW support. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_next_state;
  logic [3:0]              r_wait_cnt;
  logic                    r_we, r_uns;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_we, w_uns, w_commit, w_misalign;
  logic [1:0]              w_size, w_lane;
  logic [ADDR_WIDTH-1:0]   w_addr, w_addr_al;
  logic [ADDR_WIDTH-3:0]   w_idx;
  logic [DATA_WIDTH-1:0]   w_wdata, w_word, w_wlanes, w_load;
  logic [3:0]              w_be;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;

  // With zero wait states the commit edge is the accept edge, so the request is
  // taken straight from the ports while idle and from the latched copy otherwise.
  assign w_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_uns   = (r_state == S_IDLE) ? uns   : r_uns;
  assign w_size  = (r_state == S_IDLE) ? size  : r_size;
  assign w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (req) w_next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_wait_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_commit = (w_next_state == S_RESP);

  always_comb begin
    w_misalign = 1'b0;
    w_addr_al  = w_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
    w_misalign = ((w_size == 2'b01) && w_addr[0]) ||
                 (w_size[1] && (w_addr[1:0] != 2'b00));
`else
    if (w_size == 2'b01)  w_addr_al[0]   = 1'b0;
    else if (w_size[1])   w_addr_al[1:0] = 2'b00;
`endif
  end

  assign w_idx  = w_addr_al[ADDR_WIDTH-1:2];
  assign w_lane = w_addr_al[1:0];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_lane +: 8];
  assign w_half = w_word[16*w_lane[1] +: 16];

  // Lane enables, lane-replicated store data and extended load data share one size decode.
  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = w_wdata;
    w_load   = w_word;
    case (w_size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{w_wdata[7:0]}};
        w_load   = {{24{~w_uns & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
        w_load   = {{16{~w_uns & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && req) begin
        r_we       <= we;
        r_uns      <= uns;
        r_size     <= size;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_wait_cnt <= 4'(WAIT_STATES - 1);
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= (w_we || w_misalign) ? '0 : w_load;
        r_err   <= w_misalign;
      end
    end
  end

  // NOTE: the array has no reset; contents survive rst_n, only an aborted access is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_we && !w_misalign) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign ready = (r_state == S_RESP);
  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (0, 2 and 3 wait states) share
// the request fields; each has its own req. Expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, uns;
  logic [1:0]  size;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        req0, req2, req3;
  logic        busy0, busy2, busy3, ready0, ready2, ready3, err0, err2, err3;
  logic [31:0] rdata0, rdata2, rdata3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0));
  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .busy(busy2), .ready(ready2), .rdata(rdata2), .err(err2));
  data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .busy(busy3), .ready(ready3), .rdata(rdata3), .err(err3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int inst);
    case (inst)
      0:       return ready0;
      2:       return ready2;
      default: return ready3;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy0;
      2:       return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int inst);
    case (inst)
      0:       return rdata0;
      2:       return rdata2;
      default: return rdata3;
    endcase
  endfunction

  function automatic logic get_err(input int inst);
    case (inst)
      0:       return err0;
      2:       return err2;
      default: return err3;
    endcase
  endfunction

  task automatic set_req(input int inst, input logic v);
    case (inst)
      0:       req0 = v;
      2:       req2 = v;
      default: req3 = v;
    endcase
  endtask

  // One access; lat counts cycles from the accept edge to ready (-1 on timeout).
  task automatic access(input int inst, input logic w, input logic [1:0] sz, input logic u,
                        input logic [6:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    set_req(inst, 1'b1);
    @(negedge clk);
    set_req(inst, 1'b0);
    lat = 1;
    while (!get_ready(inst) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (get_ready(inst)) begin
      rd = get_rdata(inst);
      e  = get_err(inst);
    end else begin
      lat = -1;
      rd  = 'x;
      e   = 1'bx;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        seen;

    rst_n = 1'b0; req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = '0; wdata = '0;

    // 1: reset
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_rdata", rdata0,      32'd0);
    check("rst_err",   32'(err0),   32'd0);
    check("rst_busy3", 32'(busy3),  32'd0);
    rst_n = 1'b1;

    // 2: word store/load, zero wait states
    access(0, 1'b1, 2'b10, 1'b0, 7'h10, 32'h8899AABB, rd, e, lat);
    check("sw_lat",   32'(lat), 32'd1);
    check("sw_rdata", rd,       32'd0);
    access(0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0, rd, e, lat);
    check("lw_lat",   32'(lat), 32'd1);
    check("lw_rdata", rd,       32'h8899AABB);
    check("lw_err",   32'(e),   32'd0);

    // 3: byte/half lanes and extension
    access(0, 1'b1, 2'b00, 1'b0, 7'h11, 32'hFFFFFF7F, rd, e, lat);
    access(0, 1'b0, 2'b00, 1'b0, 7'h11, 32'h0, rd, e, lat);
    check("lb_11",  rd, 32'h0000007F);
    access(0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0, rd, e, lat);
    check("lw_10",  rd, 32'h88997FBB);
    access(0, 1'b0, 2'b01, 1'b0, 7'h12, 32'h0, rd, e, lat);
    check("lh_12",  rd, 32'hFFFF8899);
    access(0, 1'b0, 2'b01, 1'b1, 7'h12, 32'h0, rd, e, lat);
    check("lhu_12", rd, 32'h00008899);
    access(0, 1'b0, 2'b00, 1'b0, 7'h10, 32'h0, rd, e, lat);
    check("lb_10",  rd, 32'hFFFFFFBB);
    access(0, 1'b0, 2'b00, 1'b1, 7'h13, 32'h0, rd, e, lat);
    check("lbu_13", rd, 32'h00000088);
    access(0, 1'b1, 2'b10, 1'b0, 7'h14, 32'h0, rd, e, lat);
    access(0, 1'b1, 2'b01, 1'b0, 7'h16, 32'h1234CAFE, rd, e, lat);
    access(0, 1'b0, 2'b10, 1'b0, 7'h14, 32'h0, rd, e, lat);
    check("sh_16",  rd, 32'hCAFE0000);
    access(0, 1'b0, 2'b11, 1'b0, 7'h14, 32'h0, rd, e, lat);
    check("lw_rsv", rd, 32'hCAFE0000);

    // 4: three wait states, busy window and ignored req
    access(3, 1'b1, 2'b10, 1'b0, 7'h20, 32'h11223344, rd, e, lat);
    check("ws3_sw_lat", 32'(lat), 32'd4);
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 7'h20; req3 = 1'b1;       // cycle 0
    @(negedge clk); req3 = 1'b0;                                           // cycle 1
    check("ws3_c1", {busy3, ready3}, 32'b10);
    @(negedge clk);                                                        // cycle 2
    check("ws3_c2", {busy3, ready3}, 32'b10);
    req3 = 1'b1;
    @(negedge clk); req3 = 1'b0;                                           // cycle 3
    check("ws3_c3", {busy3, ready3}, 32'b10);
    @(negedge clk);                                                        // cycle 4
    check("ws3_c4", {busy3, ready3}, 32'b11);
    check("ws3_rdata", rdata3, 32'h11223344);
    @(negedge clk);
    check("ws3_c5", {busy3, ready3}, 32'b00);
    @(negedge clk);
    check("ws3_c6", {busy3, ready3}, 32'b00);

    // 5: misaligned accesses
    access(0, 1'b0, 2'b10, 1'b0, 7'h13, 32'h0, rd, e, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_lw_err",   32'(e), 32'd1);
    check("mis_lw_rdata", rd,     32'd0);
`else
    check("mis_lw_err",   32'(e), 32'd0);
    check("mis_lw_rdata", rd,     32'h88997FBB);
`endif
    access(0, 1'b1, 2'b01, 1'b0, 7'h11, 32'h0000BEEF, rd, e, lat);
    access(0, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0, rd, e, lat);
    check("mis_after_err", 32'(e), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_sh_word", rd, 32'h88997FBB);
`else
    check("mis_sh_word", rd, 32'h8899BEEF);
`endif

    // 6: reset during WAIT aborts the store
    access(2, 1'b1, 2'b10, 1'b0, 7'h20, 32'hDEADBEEF, rd, e, lat);
    check("ws2_sw_lat", 32'(lat), 32'd3);
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 7'h20; wdata = 32'h0BADF00D; req2 = 1'b1;
    @(negedge clk); req2 = 1'b0;
    check("abort_busy_wait", 32'(busy2), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("abort_busy", 32'(busy2), 32'd0);
    seen = ready2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= ready2;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    access(2, 1'b0, 2'b10, 1'b0, 7'h20, 32'h0, rd, e, lat);
    check("abort_old_data", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
